// File: rtl/addrgen_sequencer.sv
// Descriptor queue plus sequencer for one address generator: launches queued
// descriptors one at a time, holding config stable while each job runs.
module addrgen_sequencer #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned PERIOD_W = 10,
    parameter int unsigned DELAY_W  = 7,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    flush_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [ADDR_W-1:0]       desc_iter_i,
    input  logic [PERIOD_W-1:0]     desc_per_i,
    input  logic [PERIOD_W-1:0]     desc_duty_i,
    input  logic [DELAY_W-1:0]      desc_delay_i,
    input  logic [ADDR_W-1:0]       desc_start_i,
    input  logic [ADDR_W-1:0]       desc_shift_i,
    input  logic [ADDR_W-1:0]       desc_incr_i,
    output logic [ADDR_W-1:0]       gen_iter_o,
    output logic [PERIOD_W-1:0]     gen_per_o,
    output logic [PERIOD_W-1:0]     gen_duty_o,
    output logic [DELAY_W-1:0]      gen_delay_o,
    output logic [ADDR_W-1:0]       gen_start_o,
    output logic [ADDR_W-1:0]       gen_shift_o,
    output logic [ADDR_W-1:0]       gen_incr_o,
    output logic                    gen_run_o,
    input  logic                    gen_done_i,
    output logic                    busy_o,
    output logic                    idle_o,
    output logic [$clog2(DEPTH):0]  pending_o,
    output logic [CNT_W-1:0]        jobs_done_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = 4 * ADDR_W + 2 * PERIOD_W + DELAY_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StArm, StWait} state_e;

    state_e             r_state, w_state_next;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr, w_rptr_inc;
    logic [PTR_W:0]     r_count;
    logic [CNT_W-1:0]   r_jobs;
    logic [ENT_W-1:0]   w_desc, w_head;
    logic               w_push, w_pop, w_can_launch, w_job_done;

    logic [ADDR_W-1:0]   r_gen_iter, r_gen_start, r_gen_shift, r_gen_incr;
    logic [PERIOD_W-1:0] r_gen_per, r_gen_duty;
    logic [DELAY_W-1:0]  r_gen_delay;

    assign desc_ready_o = (r_count < FULL_CNT);
    assign w_push       = desc_valid_i && desc_ready_o;
    assign w_can_launch = en_i && (r_count != '0);
    assign w_desc       = {desc_iter_i, desc_per_i, desc_duty_i, desc_delay_i,
                           desc_start_i, desc_shift_i, desc_incr_i};
    assign w_head       = r_mem[r_rptr];
    assign w_rptr_inc   = r_rptr + PTR_W'(w_pop);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_job_done   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_can_launch) begin
                    w_pop        = 1'b1;
                    w_state_next = StLoad;
                end
            end
            StLoad: w_state_next = StArm;
            // Generator done is still high from the previous job here; ignore it.
            StArm:  w_state_next = StWait;
            StWait: begin
                if (gen_done_i) begin
                    w_job_done = 1'b1;
                    if (w_can_launch) begin
                        w_pop        = 1'b1;
                        w_state_next = StLoad;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_jobs  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_job_done) r_jobs <= r_jobs + CNT_W'(1);
        end
    end

    // A flush still lets a same-edge pop go to the generator; everything else is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_rptr  <= w_rptr_inc;
            r_wptr  <= w_rptr_inc;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            r_rptr  <= w_rptr_inc;
            r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= w_desc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {r_gen_iter, r_gen_per, r_gen_duty, r_gen_delay,
             r_gen_start, r_gen_shift, r_gen_incr} <= '0;
        end else if (w_pop) begin
            {r_gen_iter, r_gen_per, r_gen_duty, r_gen_delay,
             r_gen_start, r_gen_shift, r_gen_incr} <= w_head;
        end
    end

    assign gen_iter_o  = r_gen_iter;
    assign gen_per_o   = r_gen_per;
    assign gen_duty_o  = r_gen_duty;
    assign gen_delay_o = r_gen_delay;
    assign gen_start_o = r_gen_start;
    assign gen_shift_o = r_gen_shift;
    assign gen_incr_o  = r_gen_incr;
    assign gen_run_o   = (r_state == StLoad);
    assign busy_o      = (r_state != StIdle);
    assign idle_o      = (r_state == StIdle) && (r_count == '0);
    assign pending_o   = r_count;
    assign jobs_done_o = r_jobs;

endmodule

// File: tb/tb_addrgen_sequencer.sv
// Directed bench for addrgen_sequencer; the generator's done line is driven by hand.
module tb_addrgen_sequencer;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned PERIOD_W = 10;
    localparam int unsigned DELAY_W  = 7;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CNT_W    = 4;

    logic                   clk = 1'b0;
    logic                   rst_i, en_i, flush_i, desc_valid_i, desc_ready_o;
    logic [ADDR_W-1:0]      desc_iter_i, desc_start_i, desc_shift_i, desc_incr_i;
    logic [PERIOD_W-1:0]    desc_per_i, desc_duty_i;
    logic [DELAY_W-1:0]     desc_delay_i;
    logic [ADDR_W-1:0]      gen_iter_o, gen_start_o, gen_shift_o, gen_incr_o;
    logic [PERIOD_W-1:0]    gen_per_o, gen_duty_o;
    logic [DELAY_W-1:0]     gen_delay_o;
    logic                   gen_run_o, gen_done_i, busy_o, idle_o;
    logic [$clog2(DEPTH):0] pending_o;
    logic [CNT_W-1:0]       jobs_done_o;

    int unsigned      n_checks = 0;
    int unsigned      n_fail   = 0;
    logic [CNT_W-1:0] exp_jobs;

    always #5 clk = ~clk;

    addrgen_sequencer #(
        .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W), .DELAY_W(DELAY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_iter_i(desc_iter_i), .desc_per_i(desc_per_i), .desc_duty_i(desc_duty_i),
        .desc_delay_i(desc_delay_i), .desc_start_i(desc_start_i),
        .desc_shift_i(desc_shift_i), .desc_incr_i(desc_incr_i),
        .gen_iter_o(gen_iter_o), .gen_per_o(gen_per_o), .gen_duty_o(gen_duty_o),
        .gen_delay_o(gen_delay_o), .gen_start_o(gen_start_o), .gen_shift_o(gen_shift_o),
        .gen_incr_o(gen_incr_o), .gen_run_o(gen_run_o), .gen_done_i(gen_done_i),
        .busy_o(busy_o), .idle_o(idle_o), .pending_o(pending_o), .jobs_done_o(jobs_done_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_desc(input logic [9:0] iter, input logic [9:0] per,
                             input logic [9:0] duty, input logic [6:0] dly,
                             input logic [9:0] start, input logic [9:0] shift,
                             input logic [9:0] incr);
        desc_valid_i = 1'b1;
        desc_iter_i  = iter;
        desc_per_i   = per;
        desc_duty_i  = duty;
        desc_delay_i = dly;
        desc_start_i = start;
        desc_shift_i = shift;
        desc_incr_i  = incr;
        @(negedge clk);
        desc_valid_i = 1'b0;
    endtask

    // Entered at the negedge of a LOAD cycle; returns at the negedge after the done edge
    // with gen_done_i still high. Done stays high through ARM to mimic a stale done level.
    task automatic serve_job(input string tag, input logic [9:0] exp_start, input int hold,
                             input bit push_en, input logic [9:0] push_start);
        check_eq({tag, "_run"}, 32'(gen_run_o), 32'd1);
        check_eq({tag, "_start"}, 32'(gen_start_o), 32'(exp_start));
        @(negedge clk);
        check_eq({tag, "_arm_run"}, 32'(gen_run_o), 32'd0);
        @(negedge clk);
        gen_done_i = 1'b0;
        repeat (hold) @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_wait_busy"}, 32'(busy_o), 32'd1);
        gen_done_i = 1'b1;
        if (push_en) begin
            desc_valid_i = 1'b1;
            desc_start_i = push_start;
        end
        @(negedge clk);
        desc_valid_i = 1'b0;
        exp_jobs     = exp_jobs + 1'b1;
        check_eq({tag, "_jobs"}, 32'(jobs_done_o), 32'(exp_jobs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; desc_valid_i = 1'b0; gen_done_i = 1'b0;
        desc_iter_i = '0; desc_per_i = '0; desc_duty_i = '0; desc_delay_i = '0;
        desc_start_i = '0; desc_shift_i = '0; desc_incr_i = '0;
        exp_jobs = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_run", 32'(gen_run_o), 32'd0);
        check_eq("rst_pending", 32'(pending_o), 32'd0);
        check_eq("rst_jobs", 32'(jobs_done_o), 32'd0);
        check_eq("rst_idle", 32'(idle_o), 32'd1);
        check_eq("rst_start", 32'(gen_start_o), 32'd0);
        check_eq("rst_ready", 32'(desc_ready_o), 32'd1);
        rst_i = 1'b0;
        @(negedge clk);

        // 1: single job, launch latency and held config
        push_desc(10'd2, 10'd3, 10'd3, 7'd0, 10'h10, 10'd0, 10'd1);
        check_eq("t1_lat_run", 32'(gen_run_o), 32'd0);
        check_eq("t1_pending", 32'(pending_o), 32'd1);
        @(negedge clk);
        check_eq("t1_iter", 32'(gen_iter_o), 32'd2);
        check_eq("t1_per", 32'(gen_per_o), 32'd3);
        check_eq("t1_incr", 32'(gen_incr_o), 32'd1);
        serve_job("t1", 10'h10, 4, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("t1_idle", 32'(idle_o), 32'd1);
        check_eq("t1_hold_start", 32'(gen_start_o), 32'h10);

        // 2: fill the queue, overflow push ignored, zero-gap chaining in order
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_ready", 32'(desc_ready_o), 32'd1);
            push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'(i), 10'd0, 10'd0);
        end
        check_eq("t2_full_ready", 32'(desc_ready_o), 32'd0);
        desc_valid_i = 1'b1;
        desc_start_i = 10'h3F;
        @(negedge clk);
        desc_valid_i = 1'b0;
        check_eq("t2_full_pending", 32'(pending_o), 32'd4);
        en_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) serve_job("t2", 10'(i), 0, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("t2_idle", 32'(idle_o), 32'd1);

        // 3: enable gating, full-width field pass-through
        en_i = 1'b0;
        push_desc(10'h3FF, 10'h3FF, 10'h155, 7'h7F, 10'h20, 10'h3FE, 10'h200);
        push_desc(10'd5, 10'd4, 10'd2, 7'd3, 10'h21, 10'd0, 10'd1);
        repeat (3) @(negedge clk);
        check_eq("t3_en0_run", 32'(gen_run_o), 32'd0);
        check_eq("t3_en0_busy", 32'(busy_o), 32'd0);
        check_eq("t3_en0_pending", 32'(pending_o), 32'd2);
        en_i = 1'b1;
        @(negedge clk);
        check_eq("t3_run", 32'(gen_run_o), 32'd1);
        check_eq("t3_start", 32'(gen_start_o), 32'h20);
        check_eq("t3_iter", 32'(gen_iter_o), 32'h3FF);
        check_eq("t3_duty", 32'(gen_duty_o), 32'h155);
        check_eq("t3_delay", 32'(gen_delay_o), 32'h7F);
        check_eq("t3_shift", 32'(gen_shift_o), 32'h3FE);
        check_eq("t3_incr", 32'(gen_incr_o), 32'h200);
        check_eq("t3_pending1", 32'(pending_o), 32'd1);
        repeat (2) @(negedge clk);
        en_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t3_wait_busy", 32'(busy_o), 32'd1);
        gen_done_i = 1'b1;
        @(negedge clk);
        gen_done_i = 1'b0;
        exp_jobs   = exp_jobs + 1'b1;
        check_eq("t3_jobs", 32'(jobs_done_o), 32'(exp_jobs));
        repeat (3) @(negedge clk);
        check_eq("t3_nolaunch_busy", 32'(busy_o), 32'd0);
        check_eq("t3_nolaunch_pending", 32'(pending_o), 32'd1);
        en_i = 1'b1;
        @(negedge clk);
        serve_job("t3b", 10'h21, 0, 1'b0, 10'd0);
        gen_done_i = 1'b0;

        // 4: flush during a running job, flush with a coincident push
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h30, 10'd0, 10'd0);
        @(negedge clk);
        check_eq("t4_run", 32'(gen_run_o), 32'd1);
        repeat (2) @(negedge clk);
        for (int i = 1; i < 4; i++) push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'(48 + i), 10'd0, 10'd0);
        check_eq("t4_pending3", 32'(pending_o), 32'd3);
        flush_i      = 1'b1;
        desc_valid_i = 1'b1;
        desc_start_i = 10'h3E;
        @(negedge clk);
        flush_i      = 1'b0;
        desc_valid_i = 1'b0;
        check_eq("t4_flush_pending", 32'(pending_o), 32'd0);
        check_eq("t4_flush_busy", 32'(busy_o), 32'd1);
        check_eq("t4_flush_start", 32'(gen_start_o), 32'h30);
        gen_done_i = 1'b1;
        @(negedge clk);
        gen_done_i = 1'b0;
        exp_jobs   = exp_jobs + 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t4_jobs", 32'(jobs_done_o), 32'(exp_jobs));
        check_eq("t4_idle", 32'(idle_o), 32'd1);

        // 4b: flush on the launch edge keeps only the launched descriptor
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'(64 + i), 10'd0, 10'd0);
        en_i    = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t4p_pending", 32'(pending_o), 32'd0);
        serve_job("t4p", 10'h40, 0, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("t4p_idle", 32'(idle_o), 32'd1);

        // 5: full queue rejects, then push and pop on one edge keep count and order
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'(80 + i), 10'd0, 10'd0);
        check_eq("t5_full_ready", 32'(desc_ready_o), 32'd0);
        desc_valid_i = 1'b1;
        desc_start_i = 10'h5F;
        @(negedge clk);
        desc_valid_i = 1'b0;
        check_eq("t5_full_pending", 32'(pending_o), 32'd4);
        en_i = 1'b1;
        @(negedge clk);
        check_eq("t5_pending3", 32'(pending_o), 32'd3);
        serve_job("t5a", 10'h50, 0, 1'b1, 10'h54);
        check_eq("t5_pushpop_pending", 32'(pending_o), 32'd3);
        for (int i = 1; i < 5; i++) serve_job("t5", 10'(80 + i), 0, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("t5_idle", 32'(idle_o), 32'd1);

        // Job counter wrap (14 jobs so far with a 4-bit counter)
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h70, 10'd0, 10'd0);
        @(negedge clk);
        serve_job("wrap_a", 10'h70, 0, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("wrap_max", 32'(jobs_done_o), 32'd15);
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h71, 10'd0, 10'd0);
        @(negedge clk);
        serve_job("wrap_b", 10'h71, 0, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("wrap_zero", 32'(jobs_done_o), 32'd0);

        // 6: async reset during WAIT, then normal operation
        en_i = 1'b0;
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h60, 10'd0, 10'd0);
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h61, 10'd0, 10'd0);
        en_i = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_wait_busy", 32'(busy_o), 32'd1);
        check_eq("t6_pre_jobs", 32'(jobs_done_o), 32'd0);
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h62, 10'd0, 10'd0);
        #2 rst_i = 1'b1;
        #1;
        check_eq("t6_rst_busy", 32'(busy_o), 32'd0);
        check_eq("t6_rst_pending", 32'(pending_o), 32'd0);
        check_eq("t6_rst_start", 32'(gen_start_o), 32'd0);
        check_eq("t6_rst_idle", 32'(idle_o), 32'd1);
        @(negedge clk);
        rst_i    = 1'b0;
        exp_jobs = '0;
        push_desc(10'd1, 10'd1, 10'd1, 7'd0, 10'h66, 10'd0, 10'd0);
        check_eq("t6_lat_run", 32'(gen_run_o), 32'd0);
        @(negedge clk);
        serve_job("t6", 10'h66, 1, 1'b0, 10'd0);
        gen_done_i = 1'b0;
        check_eq("t6_idle", 32'(idle_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
